// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX frame arbiter.
package tx_arb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ACK,
      STREAM,
      FLUSH,
      GAP
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: search begins one past the last winner.
module rr_arbiter
   import tx_arb_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int IW      = idx_w(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               gnt_valid,
   output logic [IW-1:0]      gnt_idx
);

   int cand;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = (int'(ptr) + k) % NUM_SRC;
         if (!gnt_valid && req[IW'(cand)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC TX byte port.
// state    | meaning
// IDLE     | no grant; pick a requester when ENABLE is high
// WAIT_ACK | granted source presented to MAC, waiting for start-of-frame ACK
// STREAM   | bytes flowing, counting toward the truncation limit
// FLUSH    | frame truncated; swallow source bytes until its VALID drops
// GAP      | enforced idle time between frames
module tx_frame_arbiter
   import tx_arb_pkg::*;
#(
   parameter int NUM_SRC         = 2,
   parameter int IFG_CYCLES      = 12,
   parameter int MAX_FRAME_BYTES = 1518,
   parameter int CNT_W           = 16
) (
   input  logic                        CLK_TX,
   input  logic                        ARESET,
   input  logic                        ENABLE,
   input  logic [NUM_SRC-1:0]          SRC_DATA_VALID,
   input  logic [NUM_SRC*BYTE_W-1:0]   SRC_DATA,
   output logic [NUM_SRC-1:0]          SRC_DATA_ACK,
   output logic                        MAC_DATA_VALID,
   output logic [BYTE_W-1:0]           MAC_DATA,
   input  logic                        MAC_DATA_ACK,
   output logic [$clog2(NUM_SRC)-1:0]  GRANT_IDX,
   output logic                        BUSY,
   output logic [NUM_SRC*CNT_W-1:0]    FRAME_CNT,
   output logic                        OVERSIZE_ERR
);

   localparam int IW  = idx_w(NUM_SRC);
   localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);
   localparam int GW  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   arb_state_t          state, state_nxt;
   logic [IW-1:0]       grant_q, ptr_q, gnt_idx;
   logic                gnt_valid;
   logic [BCW-1:0]      byte_cnt;
   logic [GW-1:0]       gap_cnt;
   logic [CNT_W-1:0]    frame_cnt_q [NUM_SRC];
   logic [BYTE_W-1:0]   src_bytes [NUM_SRC];
   logic                src_valid_g;
   logic                take_grant, load_byte, inc_byte, cnt_frame, load_gap, dec_gap;

   rr_arbiter #(.NUM_SRC(NUM_SRC), .IW(IW)) u_rr (
      .req       (SRC_DATA_VALID),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_bytes[i]                 = SRC_DATA[i*BYTE_W +: BYTE_W];
         FRAME_CNT[i*CNT_W +: CNT_W]  = frame_cnt_q[i];
      end
   end

   assign src_valid_g = SRC_DATA_VALID[grant_q];
   assign GRANT_IDX   = grant_q;
   assign BUSY        = (state != IDLE);

   always_comb begin
      state_nxt      = state;
      MAC_DATA_VALID = 1'b0;
      MAC_DATA       = '0;
      SRC_DATA_ACK   = '0;
      OVERSIZE_ERR   = 1'b0;
      take_grant     = 1'b0;
      load_byte      = 1'b0;
      inc_byte       = 1'b0;
      cnt_frame      = 1'b0;
      load_gap       = 1'b0;
      dec_gap        = 1'b0;
      unique case (state)
         IDLE: begin
            if (ENABLE && gnt_valid) begin
               take_grant = 1'b1;
               state_nxt  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            MAC_DATA_VALID = src_valid_g;
            MAC_DATA       = src_bytes[grant_q];
            if (!src_valid_g) begin
               state_nxt = IDLE;
            end else if (MAC_DATA_ACK) begin
               SRC_DATA_ACK[grant_q] = 1'b1;
               load_byte             = 1'b1;
               state_nxt             = STREAM;
            end
         end
         STREAM: begin
            MAC_DATA_VALID = src_valid_g;
            MAC_DATA       = src_bytes[grant_q];
            if (!src_valid_g) begin
               cnt_frame = 1'b1;
               load_gap  = (IFG_CYCLES != 0);
               state_nxt = (IFG_CYCLES != 0) ? GAP : IDLE;
            end else if (byte_cnt == BCW'(MAX_FRAME_BYTES)) begin
               // the byte offered this cycle would exceed the limit, so hide it
               MAC_DATA_VALID = 1'b0;
               MAC_DATA       = '0;
               OVERSIZE_ERR   = 1'b1;
               state_nxt      = FLUSH;
            end else begin
               inc_byte = 1'b1;
            end
         end
         FLUSH: begin
            if (!src_valid_g) begin
               load_gap  = (IFG_CYCLES != 0);
               state_nxt = (IFG_CYCLES != 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == '0) state_nxt = IDLE;
            else               dec_gap   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_TX or posedge ARESET) begin
      if (ARESET) begin
         state    <= IDLE;
         grant_q  <= '0;
         ptr_q    <= IW'(NUM_SRC - 1);
         byte_cnt <= '0;
         gap_cnt  <= '0;
         for (int i = 0; i < NUM_SRC; i++) frame_cnt_q[i] <= '0;
      end else begin
         state <= state_nxt;
         if (take_grant) begin
            grant_q <= gnt_idx;
            ptr_q   <= gnt_idx;
         end
         if (load_byte)     byte_cnt <= BCW'(1);
         else if (inc_byte) byte_cnt <= byte_cnt + 1'b1;
         if (load_gap)      gap_cnt  <= GW'(IFG_CYCLES - 1);
         else if (dec_gap)  gap_cnt  <= gap_cnt - 1'b1;
         if (cnt_frame)     frame_cnt_q[grant_q] <= frame_cnt_q[grant_q] + 1'b1;
      end
   end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: directed frames, monitor checks MAC egress.
module tb_tx_frame_arbiter;

   localparam int IFG = 12;
   localparam int MAXB = 64;

   logic        CLK_TX = 1'b0;
   logic        ARESET;
   logic        ENABLE;
   logic [1:0]  src_v;
   logic [15:0] src_d;
   logic [1:0]  SRC_DATA_ACK;
   logic        MAC_DATA_VALID;
   logic [7:0]  MAC_DATA;
   logic        MAC_DATA_ACK;
   logic [0:0]  GRANT_IDX;
   logic        BUSY;
   logic [31:0] FRAME_CNT;
   logic        OVERSIZE_ERR;

   logic        sv [2];
   logic [7:0]  sd [2];

   logic [1:0]  z_v;
   logic [15:0] z_d;
   logic        z_ack;
   logic [1:0]  z_sack;
   logic        z_mdv;
   logic [7:0]  z_md;
   logic [0:0]  z_gi;
   logic        z_busy;
   logic [31:0] z_cnt;
   logic        z_ovf;

   always #5 CLK_TX = ~CLK_TX;

   always_comb begin
      src_v = {sv[1], sv[0]};
      src_d = {sd[1], sd[0]};
   end

   tx_frame_arbiter #(.NUM_SRC(2), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB), .CNT_W(16)) dut (
      .CLK_TX(CLK_TX), .ARESET(ARESET), .ENABLE(ENABLE),
      .SRC_DATA_VALID(src_v), .SRC_DATA(src_d), .SRC_DATA_ACK(SRC_DATA_ACK),
      .MAC_DATA_VALID(MAC_DATA_VALID), .MAC_DATA(MAC_DATA), .MAC_DATA_ACK(MAC_DATA_ACK),
      .GRANT_IDX(GRANT_IDX), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .OVERSIZE_ERR(OVERSIZE_ERR)
   );

   tx_frame_arbiter #(.NUM_SRC(2), .IFG_CYCLES(0), .MAX_FRAME_BYTES(MAXB), .CNT_W(16)) dut_z (
      .CLK_TX(CLK_TX), .ARESET(ARESET), .ENABLE(ENABLE),
      .SRC_DATA_VALID(z_v), .SRC_DATA(z_d), .SRC_DATA_ACK(z_sack),
      .MAC_DATA_VALID(z_mdv), .MAC_DATA(z_md), .MAC_DATA_ACK(z_ack),
      .GRANT_IDX(z_gi), .BUSY(z_busy), .FRAME_CNT(z_cnt), .OVERSIZE_ERR(z_ovf)
   );

   typedef struct {
      int         src;
      int         len;
      logic [7:0] seed;
   } exp_t;

   exp_t expq[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   ack_delay = 0;
   bit   mon_in = 0;
   int   mon_idx = 0;
   int   low_run = 0;
   bit   had_frame = 0;
   bit   gap_check = 0;
   int   ovf_cnt = 0;
   bit   abort_src = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int src, input int len, input logic [7:0] seed);
      exp_t e;
      e.src  = src;
      e.len  = (len > MAXB) ? MAXB : len;
      e.seed = seed;
      return e;
   endfunction

   // Monitor: frame starts on the ACK cycle; every sampled byte is compared in order.
   initial forever begin
      @(negedge CLK_TX);
      if (OVERSIZE_ERR) ovf_cnt++;
      if (ARESET) begin
         mon_in = 0;
      end else if (!mon_in) begin
         if (MAC_DATA_VALID && MAC_DATA_ACK) begin
            if (expq.size() == 0) begin
               check("unexpected_frame", 1, 0);
            end else begin
               cur = expq.pop_front();
               check("grant_idx", GRANT_IDX, cur.src);
               check("src_ack_route", SRC_DATA_ACK, 1 << cur.src);
               check("byte0", MAC_DATA, cur.seed);
               if (gap_check && had_frame) check("ifg_low_cycles", low_run, IFG + 2);
               mon_in  = 1;
               mon_idx = 1;
            end
         end else if (!MAC_DATA_VALID) begin
            low_run++;
         end
      end else if (MAC_DATA_VALID) begin
         check("byte", MAC_DATA, 8'(cur.seed + mon_idx));
         mon_idx++;
      end else begin
         check("frame_len", mon_idx, cur.len);
         mon_in    = 0;
         low_run   = 1;
         had_frame = 1;
      end
   end

   // MAC sink: ACK one cycle after ack_delay cycles of MAC_DATA_VALID.
   initial begin
      bit in_fr = 0;
      int wcnt  = 0;
      MAC_DATA_ACK = 1'b0;
      forever begin
         @(posedge CLK_TX);
         #2;
         if (ARESET) begin
            MAC_DATA_ACK = 1'b0;
            in_fr = 0;
            wcnt  = 0;
         end else if (MAC_DATA_ACK) begin
            MAC_DATA_ACK = 1'b0;
         end else if (in_fr) begin
            if (!MAC_DATA_VALID) in_fr = 0;
         end else if (MAC_DATA_VALID) begin
            if (wcnt >= ack_delay) begin
               MAC_DATA_ACK = 1'b1;
               in_fr = 1;
               wcnt  = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic drive_frame(input int src, input int len, input logic [7:0] seed);
      int idx = 0;
      bit started = 0;
      bit adv;
      int guard = 0;
      @(posedge CLK_TX);
      #1;
      sv[src] = 1'b1;
      sd[src] = seed;
      while (idx < len && !abort_src) begin
         @(negedge CLK_TX);
         if (SRC_DATA_ACK[src]) started = 1;
         adv = started;
         @(posedge CLK_TX);
         #1;
         if (adv) begin
            idx++;
            if (idx < len) sd[src] = 8'(seed + idx);
         end
         guard++;
         if (guard > 2000) begin
            check("src_timeout", guard, 0);
            break;
         end
      end
      sv[src] = 1'b0;
      sd[src] = 8'h00;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge CLK_TX);
         n++;
      end while (!(expq.size() == 0 && !mon_in && !BUSY) && n < 3000);
      if (n >= 3000) check(name, 0, 1);
   endtask

   task automatic pulse_reset();
      @(posedge CLK_TX);
      #1 ARESET = 1'b1;
      repeat (2) @(posedge CLK_TX);
      #1 ARESET = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int n;
      ARESET = 1'b1;
      ENABLE = 1'b1;
      sv[0] = 1'b0; sv[1] = 1'b0;
      sd[0] = 8'h00; sd[1] = 8'h00;
      z_v = '0; z_d = '0; z_ack = 1'b0;

      // Reset values
      repeat (2) @(negedge CLK_TX);
      check("rst_mac_valid", MAC_DATA_VALID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_grant", GRANT_IDX, 0);
      check("rst_frame_cnt", FRAME_CNT, 0);
      check("rst_src_ack", SRC_DATA_ACK, 0);
      check("rst_oversize", OVERSIZE_ERR, 0);
      @(posedge CLK_TX);
      #1 ARESET = 1'b0;

      // 1: single 42-byte frame from src0, ACK after 2 cycles
      ack_delay = 2;
      expq.push_back(mk(0, 42, 8'h10));
      drive_frame(0, 42, 8'h10);
      wait_idle("t1_drain");
      check("t1_cnt0", FRAME_CNT[15:0], 1);
      check("t1_cnt1", FRAME_CNT[31:16], 0);

      // 2: both sources, three frames each, alternating; low run = end cycle + IFG + grant cycle
      pulse_reset();
      ack_delay = 0;
      had_frame = 0;
      gap_check = 1;
      expq.push_back(mk(0, 10, 8'h20));
      expq.push_back(mk(1, 15, 8'hA0));
      expq.push_back(mk(0, 11, 8'h40));
      expq.push_back(mk(1, 16, 8'hB0));
      expq.push_back(mk(0, 12, 8'h60));
      expq.push_back(mk(1, 17, 8'hC0));
      fork
         begin
            drive_frame(0, 10, 8'h20);
            drive_frame(0, 11, 8'h40);
            drive_frame(0, 12, 8'h60);
         end
         begin
            drive_frame(1, 15, 8'hA0);
            drive_frame(1, 16, 8'hB0);
            drive_frame(1, 17, 8'hC0);
         end
      join
      wait_idle("t2_drain");
      gap_check = 0;
      check("t2_cnt0", FRAME_CNT[15:0], 3);
      check("t2_cnt1", FRAME_CNT[31:16], 3);

      // 3: src1 sends 100 bytes, truncated at 64; src0 waits behind it
      ack_delay = 1;
      ovf_cnt = 0;
      expq.push_back(mk(1, 100, 8'h01));
      expq.push_back(mk(0, 8, 8'h77));
      fork
         begin
            drive_frame(1, 100, 8'h01);
            n = 0;
            while (n < 200) begin
               @(negedge CLK_TX);
               if (MAC_DATA_VALID) break;
               n++;
            end
            check("t3_gap_after_flush", n, IFG + 2);
         end
         begin
            repeat (5) @(posedge CLK_TX);
            drive_frame(0, 8, 8'h77);
         end
      join
      wait_idle("t3_drain");
      check("t3_oversize_pulses", ovf_cnt, 1);
      check("t3_cnt1", FRAME_CNT[31:16], 3);
      check("t3_cnt0", FRAME_CNT[15:0], 4);

      // 4: ENABLE low holds a pending request; grant follows one cycle after ENABLE
      @(posedge CLK_TX);
      #1 ENABLE = 1'b0;
      expq.push_back(mk(0, 6, 8'h33));
      fork
         drive_frame(0, 6, 8'h33);
         begin
            repeat (6) @(negedge CLK_TX);
            check("t4_hold_busy", BUSY, 0);
            check("t4_hold_ack", SRC_DATA_ACK, 0);
            check("t4_hold_valid", MAC_DATA_VALID, 0);
            @(posedge CLK_TX);
            #1 ENABLE = 1'b1;
            @(negedge CLK_TX);
            check("t4_decide_busy", BUSY, 0);
            @(negedge CLK_TX);
            check("t4_grant_valid", MAC_DATA_VALID, 1);
            check("t4_grant_busy", BUSY, 1);
            check("t4_grant_idx", GRANT_IDX, 0);
         end
      join
      wait_idle("t4_drain");
      check("t4_cnt0", FRAME_CNT[15:0], 5);

      // 5: reset in the middle of a frame, then src0 wins a simultaneous request
      ack_delay = 0;
      expq.push_back(mk(0, 40, 8'h50));
      fork
         drive_frame(0, 40, 8'h50);
         begin
            n = 0;
            while (n < 500) begin
               @(negedge CLK_TX);
               #1;
               if (mon_in && mon_idx >= 20) break;
               n++;
            end
            ARESET = 1'b1;
            #1;
            check("t5_rst_valid", MAC_DATA_VALID, 0);
            check("t5_rst_busy", BUSY, 0);
            check("t5_rst_cnt", FRAME_CNT, 0);
            check("t5_rst_ack", SRC_DATA_ACK, 0);
            check("t5_rst_grant", GRANT_IDX, 0);
            abort_src = 1;
            repeat (2) @(posedge CLK_TX);
            #1 ARESET = 1'b0;
         end
      join
      abort_src = 0;
      expq.push_back(mk(0, 5, 8'hE0));
      expq.push_back(mk(1, 5, 8'hF0));
      fork
         drive_frame(0, 5, 8'hE0);
         drive_frame(1, 5, 8'hF0);
      join
      wait_idle("t5_drain");
      check("t5_cnt0", FRAME_CNT[15:0], 1);
      check("t5_cnt1", FRAME_CNT[31:16], 1);

      // 6: zero-gap instance, back-to-back frames from src0
      @(posedge CLK_TX);
      #1 z_v[0] = 1'b1; z_d[7:0] = 8'h11;
      @(negedge CLK_TX);
      check("t6_idle_valid", z_mdv, 0);
      @(posedge CLK_TX);
      #1 z_ack = 1'b1;
      @(negedge CLK_TX);
      check("t6_wait_valid", z_mdv, 1);
      check("t6_wait_data", z_md, 8'h11);
      check("t6_sack", z_sack, 1);
      @(posedge CLK_TX);
      #1 z_ack = 1'b0; z_d[7:0] = 8'h12;
      @(posedge CLK_TX);
      #1 z_ack = 1'b1; z_d[7:0] = 8'h13;
      @(negedge CLK_TX);
      check("t6_stray_ack", z_sack, 0);
      check("t6_stream_data", z_md, 8'h13);
      @(posedge CLK_TX);
      #1 z_ack = 1'b0; z_v[0] = 1'b0; z_d[7:0] = 8'h00;
      @(posedge CLK_TX);
      #1 z_v[0] = 1'b1; z_d[7:0] = 8'h21;
      @(negedge CLK_TX);
      check("t6_idle_busy", z_busy, 0);
      check("t6_cnt_first", z_cnt[15:0], 1);
      @(negedge CLK_TX);
      check("t6_regrant_valid", z_mdv, 1);
      check("t6_regrant_busy", z_busy, 1);
      check("t6_regrant_data", z_md, 8'h21);
      #1 z_ack = 1'b1;
      @(posedge CLK_TX);
      #1 z_ack = 1'b0; z_v[0] = 1'b0; z_d[7:0] = 8'h00;
      @(posedge CLK_TX);
      @(negedge CLK_TX);
      check("t6_cnt_second", z_cnt[15:0], 2);
      check("t6_no_oversize", z_ovf, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
